// File: rtl/game_countdown_timer.sv
// Whack-A-Button round timer: four presets, start/pause/restart control,
// saturating time bonus, expiry pulse and BCD digits for the hex displays.
module game_countdown_timer #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int WIDTH           = 8,
  parameter int MAX_COUNT       = 99,
  parameter int PRESET0         = 30,
  parameter int PRESET1         = 60,
  parameter int PRESET2         = 90,
  parameter int PRESET3         = 15
) (
  input  logic             ClockIn,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Pause,
  input  logic [1:0]       Mode,
  input  logic             Speed,
  input  logic             AddTime,
  input  logic [WIDTH-1:0] AddAmount,
  output logic [WIDTH-1:0] CounterValue,
  output logic             Running,
  output logic             Expired,
  output logic             ExpirePulse,
  output logic             Tick,
  output logic [3:0]       BcdHundreds,
  output logic [3:0]       BcdTens,
  output logic [3:0]       BcdOnes
);

  localparam int PW = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [PW-1:0]    PRESC_TOP = PW'(CLOCK_FREQUENCY - 1);
  localparam logic [PW-1:0]    PRESC_ONE = PW'(1'b1);
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   MAX_EXT   = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0]   ONE_EXT   = (WIDTH+1)'(1'b1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  function automatic logic [WIDTH-1:0] clamp_preset(input int p);
    return (p > MAX_COUNT) ? WIDTH'(MAX_COUNT) : WIDTH'(p);
  endfunction

  function automatic logic [11:0] to_bcd(input logic [WIDTH-1:0] v);
    logic [11:0] b;
    b = 12'd0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (b[3:0] > 4'd4) b[3:0] = b[3:0] + 4'd3;
      if (b[7:4] > 4'd4) b[7:4] = b[7:4] + 4'd3;
      if (b[11:8] > 4'd4) b[11:8] = b[11:8] + 4'd3;
      b = {b[10:0], v[i]};
    end
    return b;
  endfunction

  localparam logic [WIDTH-1:0] LOAD0 = clamp_preset(PRESET0);
  localparam logic [WIDTH-1:0] LOAD1 = clamp_preset(PRESET1);
  localparam logic [WIDTH-1:0] LOAD2 = clamp_preset(PRESET2);
  localparam logic [WIDTH-1:0] LOAD3 = clamp_preset(PRESET3);

  logic [1:0]       state_r, state_s;
  logic [WIDTH-1:0] count_r, count_s, load_s, add_s, sat_s;
  logic [PW-1:0]    presc_r, presc_s, reload_s;
  logic             pulse_r, pulse_s, tick_s;
  logic [WIDTH:0]   sum_s, adj_s;
  logic [11:0]      bcd_s;

  // Preset selection, tick qualification and saturating bonus/decrement arithmetic.
  always_comb begin
    case (Mode)
      2'd0:    load_s = LOAD0;
      2'd1:    load_s = LOAD1;
      2'd2:    load_s = LOAD2;
      default: load_s = LOAD3;
    endcase
    reload_s = Speed ? PRESC_TOP : {PW{1'b0}};
    tick_s   = (state_r == ST_RUNNING) && (presc_r == {PW{1'b0}}) && !Pause;
    add_s    = AddTime ? AddAmount : {WIDTH{1'b0}};
    sum_s    = {1'b0, count_r} + {1'b0, add_s};
    // A pending tick at zero (zero preset) must not wrap the count.
    if (tick_s && (sum_s != {(WIDTH+1){1'b0}})) begin
      adj_s = sum_s - ONE_EXT;
    end else begin
      adj_s = sum_s;
    end
    if (adj_s > MAX_EXT) begin
      sat_s = MAX_VAL;
    end else begin
      sat_s = adj_s[WIDTH-1:0];
    end
  end

  // Control FSM next-state: restart has priority over everything but reset.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    presc_s = presc_r;
    pulse_s = 1'b0;
    if (Start) begin
      state_s = ST_RUNNING;
      count_s = load_s;
      presc_s = reload_s;
    end else begin
      case (state_r)
        ST_IDLE: count_s = load_s;
        ST_RUNNING: begin
          count_s = sat_s;
          // A tick held off by Pause stays pending at zero rather than being lost.
          if (presc_r != {PW{1'b0}}) begin
            presc_s = presc_r - PRESC_ONE;
          end else if (!Pause) begin
            presc_s = reload_s;
          end else begin
            presc_s = presc_r;
          end
          if (sat_s == {WIDTH{1'b0}}) begin
            state_s = ST_EXPIRED;
            pulse_s = 1'b1;
          end else if (Pause) begin
            state_s = ST_PAUSED;
          end else begin
            state_s = ST_RUNNING;
          end
        end
        ST_PAUSED: begin
          count_s = sat_s;
          if (Pause) begin
            state_s = ST_PAUSED;
          end else begin
            state_s = ST_RUNNING;
          end
        end
        ST_EXPIRED: count_s = {WIDTH{1'b0}};
        default:    state_s = ST_IDLE;
      endcase
    end
  end

  // State, count, prescaler and expiry pulse registers.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      count_r <= load_s;
      presc_r <= {PW{1'b0}};
      pulse_r <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      presc_r <= presc_s;
      pulse_r <= pulse_s;
    end
  end

  assign bcd_s        = to_bcd(count_r);
  assign CounterValue = count_r;
  assign Running      = (state_r == ST_RUNNING);
  assign Expired      = (state_r == ST_EXPIRED);
  assign ExpirePulse  = pulse_r;
  assign Tick         = tick_s;
  assign BcdHundreds  = bcd_s[11:8];
  assign BcdTens      = bcd_s[7:4];
  assign BcdOnes      = bcd_s[3:0];

endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer: per-cycle comparison against a behavioural
// model for two instances (standard presets and a zero preset on Mode 0).
module tb_game_countdown_timer;

  localparam int CF   = 4;
  localparam int MAXC = 99;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAU = 2, S_EXP = 3;

  logic       ClockIn = 1'b0;
  logic       Reset, Start, zstart, Pause, Speed, AddTime;
  logic [1:0] Mode;
  logic [7:0] AddAmount;

  logic [7:0] a_cnt, z_cnt;
  logic       a_run, a_exp, a_pl, a_tk, z_run, z_exp, z_pl, z_tk;
  logic [3:0] a_h, a_t, a_o, z_h, z_t, z_o;

  game_countdown_timer #(.CLOCK_FREQUENCY(CF), .WIDTH(8), .MAX_COUNT(MAXC),
    .PRESET0(30), .PRESET1(60), .PRESET2(90), .PRESET3(15)) dut (
    .ClockIn(ClockIn), .Reset(Reset), .Start(Start), .Pause(Pause), .Mode(Mode),
    .Speed(Speed), .AddTime(AddTime), .AddAmount(AddAmount), .CounterValue(a_cnt),
    .Running(a_run), .Expired(a_exp), .ExpirePulse(a_pl), .Tick(a_tk),
    .BcdHundreds(a_h), .BcdTens(a_t), .BcdOnes(a_o));

  game_countdown_timer #(.CLOCK_FREQUENCY(CF), .WIDTH(8), .MAX_COUNT(MAXC),
    .PRESET0(0), .PRESET1(60), .PRESET2(90), .PRESET3(15)) dut_z (
    .ClockIn(ClockIn), .Reset(Reset), .Start(zstart), .Pause(Pause), .Mode(Mode),
    .Speed(Speed), .AddTime(AddTime), .AddAmount(AddAmount), .CounterValue(z_cnt),
    .Running(z_run), .Expired(z_exp), .ExpirePulse(z_pl), .Tick(z_tk),
    .BcdHundreds(z_h), .BcdTens(z_t), .BcdOnes(z_o));

  always #5 ClockIn = ~ClockIn;

  typedef struct packed { int st; int cnt; int pre; bit pulse; } mst_t;

  mst_t ma = '0, mz = '0;
  int   checks = 0, errors = 0;
  bit   armed = 1'b0;

  function automatic int preset_of(input int mode, input int p0);
    int p;
    case (mode)
      0:       p = p0;
      1:       p = 60;
      2:       p = 90;
      default: p = 15;
    endcase
    return (p > MAXC) ? MAXC : p;
  endfunction

  function automatic bit mtick(input mst_t m, input bit pause);
    return (m.st == S_RUN) && (m.pre == 0) && !pause;
  endfunction

  // Seconds remaining, cycles left in the current second, and round phase.
  function automatic mst_t mstep(input mst_t m, input bit rst, input bit st, input int p0);
    mst_t n;
    int   v;
    n = m;
    n.pulse = 1'b0;
    v = m.cnt + (AddTime ? int'(AddAmount) : 0);
    if (mtick(m, Pause) && v > 0) v = v - 1;
    if (v > MAXC) v = MAXC;
    if (rst) begin
      n.st = S_IDLE; n.cnt = preset_of(Mode, p0); n.pre = 0;
    end else if (st) begin
      n.st = S_RUN; n.cnt = preset_of(Mode, p0); n.pre = Speed ? CF - 1 : 0;
    end else if (m.st == S_IDLE) begin
      n.cnt = preset_of(Mode, p0);
    end else if (m.st == S_RUN) begin
      n.cnt = v;
      if (m.pre > 0) n.pre = m.pre - 1;
      else if (!Pause) n.pre = Speed ? CF - 1 : 0;
      if (v == 0) begin n.st = S_EXP; n.pulse = 1'b1; end
      else if (Pause) n.st = S_PAU;
    end else if (m.st == S_PAU) begin
      n.cnt = v;
      if (!Pause) n.st = S_RUN;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input mst_t m, input logic [7:0] cv, input logic run,
                     input logic ex, input logic pl, input logic tk,
                     input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    chk({tag, ".CounterValue"}, cv, m.cnt);
    chk({tag, ".Running"}, run, m.st == S_RUN);
    chk({tag, ".Expired"}, ex, m.st == S_EXP);
    chk({tag, ".ExpirePulse"}, pl, m.pulse);
    chk({tag, ".Tick"}, tk, mtick(m, Pause));
    chk({tag, ".BcdHundreds"}, h, m.cnt / 100);
    chk({tag, ".BcdTens"}, t, (m.cnt / 10) % 10);
    chk({tag, ".BcdOnes"}, o, m.cnt % 10);
  endtask

  always @(posedge ClockIn) begin
    ma = mstep(ma, Reset, Start, 30);
    mz = mstep(mz, Reset, zstart, 0);
  end

  always @(negedge ClockIn) begin
    if (armed) begin
      cmp("a", ma, a_cnt, a_run, a_exp, a_pl, a_tk, a_h, a_t, a_o);
      cmp("z", mz, z_cnt, z_run, z_exp, z_pl, z_tk, z_h, z_t, z_o);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge ClockIn);
      #1;
    end
  endtask

  task automatic wait_cnt(input int target, input int limit);
    int n;
    n = 0;
    while (a_cnt !== 8'(target) && n < limit) begin
      step();
      n++;
    end
    chk("wait_cnt", a_cnt, target);
  endtask

  initial begin
    int n, pulses;
    Reset = 1'b1; Start = 1'b0; zstart = 1'b0; Pause = 1'b0; Speed = 1'b0;
    AddTime = 1'b0; AddAmount = 8'd0; Mode = 2'd1;
    step();
    armed = 1'b1;
    step();
    chk("reset_cnt", a_cnt, 60);
    chk("reset_running", a_run, 0);
    chk("reset_expired", a_exp, 0);
    Reset = 1'b0;

    // Mode 1, one tick per cycle, run to expiry
    Start = 1'b1; step();
    chk("start_cnt", a_cnt, 60);
    chk("start_tens", a_t, 6);
    chk("start_ones", a_o, 0);
    Start = 1'b0; step();
    chk("first_dec", a_cnt, 59);
    n = 0; pulses = 0;
    while (a_exp !== 1'b1 && n < 100) begin
      step(); n++; pulses += int'(a_pl);
    end
    chk("expiry_steps", n, 59);
    step(3);
    pulses += 0;
    chk("pulse_count", pulses, 1);
    chk("expired_hold", a_exp, 1);
    chk("expired_cnt", a_cnt, 0);

    // Restart from EXPIRED: Mode 3, prescaled ticks, pause mid-second
    Mode = 2'd3; Speed = 1'b1; Start = 1'b1; step();
    chk("m3_start", a_cnt, 15);
    Start = 1'b0; step(2);
    chk("m3_hold", a_cnt, 15);
    step();
    chk("m3_tick", a_tk, 1);
    step();
    chk("m3_dec", a_cnt, 14);
    step();
    Pause = 1'b1; step(3);
    chk("paused_running", a_run, 0);
    Pause = 1'b0;
    n = 0;
    while (a_cnt === 8'd14 && n < 20) begin
      step(); n++;
    end
    chk("pause_delay", n, 3);
    chk("after_pause", a_cnt, 13);

    // Mode 0 bonus saturation and bonus coinciding with the final tick
    Mode = 2'd0; Start = 1'b1; step();
    chk("m0_start", a_cnt, 30);
    Start = 1'b0; AddTime = 1'b1; AddAmount = 8'd65; step();
    chk("bonus_95", a_cnt, 95);
    AddAmount = 8'd10; step();
    chk("bonus_sat", a_cnt, 99);
    AddTime = 1'b0; AddAmount = 8'd0; Speed = 1'b0;
    wait_cnt(1, 200);
    chk("tick_at_one", a_tk, 1);
    AddTime = 1'b1; AddAmount = 8'd5; step();
    chk("bonus_at_one", a_cnt, 5);
    chk("no_expiry", a_exp, 0);
    AddTime = 1'b0; AddAmount = 8'd0;

    // Mode change mid-run ignored; restart while running
    Mode = 2'd2; Start = 1'b1; step();
    chk("m2_start", a_cnt, 90);
    Start = 1'b0; Mode = 2'd0; step(3);
    chk("mode_ignored", a_cnt, 87);
    wait_cnt(17, 200);
    Mode = 2'd2; Start = 1'b1; step();
    chk("restart_90", a_cnt, 90);
    Start = 1'b0; step();
    chk("restart_dec", a_cnt, 89);

    // Reset mid-count and while paused
    Reset = 1'b1; step();
    chk("rst_run_cnt", a_cnt, 90);
    chk("rst_run_running", a_run, 0);
    chk("rst_run_pulse", a_pl, 0);
    Reset = 1'b0; Mode = 2'd1; Speed = 1'b1; Start = 1'b1; step();
    Start = 1'b0; Pause = 1'b1; step(2);
    chk("paused_cnt", a_cnt, 60);
    Reset = 1'b1; step();
    chk("rst_pau_cnt", a_cnt, 60);
    chk("rst_pau_expired", a_exp, 0);
    Reset = 1'b0; Pause = 1'b0;

    // Bonus ignored in IDLE and EXPIRED
    AddTime = 1'b1; AddAmount = 8'd5; step();
    chk("idle_bonus", a_cnt, 60);
    AddTime = 1'b0; Mode = 2'd3; Speed = 1'b0; Start = 1'b1; step();
    Start = 1'b0;
    n = 0;
    while (a_exp !== 1'b1 && n < 40) begin
      step(); n++;
    end
    chk("m3_expire_steps", n, 15);
    AddTime = 1'b1; AddAmount = 8'd7; step(2);
    chk("exp_bonus", a_cnt, 0);
    AddTime = 1'b0; AddAmount = 8'd0;

    // Zero preset instance
    Mode = 2'd0; zstart = 1'b1; step();
    chk("z_start_cnt", z_cnt, 0);
    chk("z_start_running", z_run, 1);
    zstart = 1'b0; step();
    chk("z_expired", z_exp, 1);
    chk("z_pulse", z_pl, 1);
    step();
    chk("z_pulse_end", z_pl, 0);
    AddTime = 1'b1; AddAmount = 8'd9; step();
    chk("z_exp_bonus", z_cnt, 0);
    AddTime = 1'b0; AddAmount = 8'd0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
